// File: rtl/bsg_chip_pkg.sv
// rtl/bsg_chip_pkg.sv - shared chip types: router tag payload, reset sequencer states
package bsg_chip_pkg;

    localparam int wh_cord_width_gp = 7;

    typedef struct packed {
        logic                        reset;
        logic [wh_cord_width_gp-1:0] cord;
    } bsg_chip_router_tag_payload_s;

    typedef enum logic [1:0] {
        e_hold,
        e_stagger,
        e_run
    } router_seq_state_e;

    // Width helper that never returns 0, so single-entry counters still get a bit.
    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bsg_counter_set_down.sv
// rtl/bsg_counter_set_down.sv - loadable down counter; set_i has priority over down_i
module bsg_counter_set_down #(
    parameter int width_p    = 4,
    parameter int init_val_p = 0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               set_i,
    input  logic [width_p-1:0] val_i,
    input  logic               down_i,
    output logic [width_p-1:0] count_r_o
);

    logic [width_p-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (set_i)
            count_d = val_i;
        else if (down_i)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            count_q <= width_p'(init_val_p);
        else
            count_q <= count_d;
    end

    assign count_r_o = count_q;

endmodule

// File: rtl/bsg_chip_router_reset_sequencer.sv
// rtl/bsg_chip_router_reset_sequencer.sv - staggered router reset release with per-router cord latching
module bsg_chip_router_reset_sequencer
    import bsg_chip_pkg::*;
#(
    parameter int num_router_p     = 4,
    parameter int cord_width_p     = 7,
    parameter int stagger_cycles_p = 4
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [num_router_p-1:0]              tag_new_i,
    input  logic [num_router_p-1:0]              tag_reset_i,
    input  logic [num_router_p*cord_width_p-1:0] tag_cord_i,
    output logic [num_router_p-1:0]              router_reset_o,
    output logic [num_router_p*cord_width_p-1:0] router_cord_o,
    output logic                                 any_reset_o,
    output logic                                 ready_o,
    output logic                                 cord_err_o
);

    localparam int cnt_width_lp = safe_clog2(stagger_cycles_p + 1);
    localparam int idx_width_lp = safe_clog2(num_router_p);
    localparam logic [cnt_width_lp-1:0] reload_lp   = cnt_width_lp'(stagger_cycles_p - 1);
    localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(num_router_p - 1);

    logic [num_router_p-1:0]              seen_q, seen_d;
    logic [num_router_p-1:0]              req_reset_q, req_reset_d;
    logic [num_router_p-1:0]              router_reset_q, router_reset_d;
    logic [num_router_p*cord_width_p-1:0] cord_q, cord_d;
    logic                                 cord_err_q, cord_err_d;
    logic                                 ready_q, ready_d;
    router_seq_state_e                    state_q, state_d;
    logic [idx_width_lp-1:0]              idx_q, idx_d;

    logic [num_router_p-1:0] cord_latch;
    logic [num_router_p-1:0] cord_err_hit;
    logic                    reassert;
    logic                    cnt_set, cnt_down;
    logic [cnt_width_lp-1:0] cnt_val, cnt_r;

    assign reassert = |(tag_new_i & tag_reset_i);

    // A reset payload anywhere forces every router back into reset this edge,
    // so its cord may be taken even if the router is currently released.
    for (genvar i = 0; i < num_router_p; i++) begin : g_capture
        assign seen_d[i]      = seen_q[i] | tag_new_i[i];
        assign req_reset_d[i] = tag_new_i[i] ? tag_reset_i[i] : req_reset_q[i];
        assign cord_latch[i]  = tag_new_i[i] & (router_reset_q[i] | reassert);
        assign cord_d[i*cord_width_p +: cord_width_p] = cord_latch[i]
            ? tag_cord_i[i*cord_width_p +: cord_width_p]
            : cord_q[i*cord_width_p +: cord_width_p];
        assign cord_err_hit[i] = tag_new_i[i] & ~cord_latch[i]
            & (tag_cord_i[i*cord_width_p +: cord_width_p] != cord_q[i*cord_width_p +: cord_width_p]);
    end

    bsg_counter_set_down #(
        .width_p    (cnt_width_lp),
        .init_val_p (0)
    ) stagger_cnt (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .set_i     (cnt_set),
        .val_i     (cnt_val),
        .down_i    (cnt_down),
        .count_r_o (cnt_r)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        router_reset_d = router_reset_q;
        cnt_set        = 1'b0;
        cnt_val        = '0;
        cnt_down       = 1'b0;

        case (state_q)
            e_hold: begin
                router_reset_d = '1;
                if (&seen_q && !(|req_reset_q)) begin
                    router_reset_d[0] = 1'b0;
                    if (num_router_p == 1) begin
                        state_d = e_run;
                    end else begin
                        state_d = e_stagger;
                        idx_d   = idx_width_lp'(1);
                        cnt_set = 1'b1;
                        cnt_val = reload_lp;
                    end
                end
            end
            e_stagger: begin
                if (cnt_r == '0) begin
                    router_reset_d[idx_q] = 1'b0;
                    if (idx_q == last_idx_lp) begin
                        state_d = e_run;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        cnt_set = 1'b1;
                        cnt_val = reload_lp;
                    end
                end else begin
                    cnt_down = 1'b1;
                end
            end
            e_run: begin
            end
            default: state_d = e_hold;
        endcase

        // Re-assertion wins over any release decided above.
        if (reassert) begin
            router_reset_d = '1;
            state_d        = e_hold;
            idx_d          = '0;
            cnt_set        = 1'b1;
            cnt_val        = '0;
            cnt_down       = 1'b0;
        end

        ready_d    = (state_q == e_run) & ~reassert;
        cord_err_d = cord_err_q | (|cord_err_hit);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            seen_q         <= '0;
            req_reset_q    <= '1;
            router_reset_q <= '1;
            cord_q         <= '0;
            cord_err_q     <= 1'b0;
            ready_q        <= 1'b0;
            state_q        <= e_hold;
            idx_q          <= '0;
        end else begin
            seen_q         <= seen_d;
            req_reset_q    <= req_reset_d;
            router_reset_q <= router_reset_d;
            cord_q         <= cord_d;
            cord_err_q     <= cord_err_d;
            ready_q        <= ready_d;
            state_q        <= state_d;
            idx_q          <= idx_d;
        end
    end

    assign router_reset_o = router_reset_q;
    assign router_cord_o  = cord_q;
    assign any_reset_o    = |router_reset_q;
    assign ready_o        = ready_q;
    assign cord_err_o     = cord_err_q;

endmodule

// File: doc/bsg_chip_router_reset_sequencer.md
Name: bsg_chip_router_reset_sequencer

Overview:
- Parametrised successor to the per-router tag-client reset/cord join in the chip toplevel.
- Generalises the join to num_router_p routers with configurable cord width.
- Replaces the plain OR-of-resets with a sequenced, staggered reset release, per-router cord latching and a ready indication.
- Sits in the router clock domain, between the bsg_tag_client bank (already synchronised outputs) and the router/tile/memory mesh.

Parameters:
- num_router_p, 4, number of routers sequenced; must be >= 1.
- cord_width_p, 7, width of each router cord (wh_cord_width_gp in the chip).
- stagger_cycles_p, 4, cycles between successive router reset releases; must be >= 1.
- cnt_width_lp, `BSG_SAFE_CLOG2(stagger_cycles_p+1), localparam, stagger counter width.
- idx_width_lp, `BSG_SAFE_CLOG2(num_router_p), localparam, release-index width.

Ports:
- clk_i  in  1  router clock.
- reset_i  in  1  synchronous reset, active-high.
- tag_new_i  in  num_router_p  per-router one-cycle pulse: new tag payload present.
- tag_reset_i  in  num_router_p  reset field of each payload.
- tag_cord_i  in  num_router_p*cord_width_p  cord field of each payload.
- router_reset_o  out  num_router_p  registered per-router reset.
- router_cord_o  out  num_router_p*cord_width_p  registered latched cords.
- any_reset_o  out  1  OR of router_reset_o.
- ready_o  out  1  high only in state RUN.
- cord_err_o  out  1  sticky: cord change attempted on a released router.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - router_reset_o all 1; router_cord_o all 0.
  - seen_r 0, req_reset_r all 1.
  - state HOLD, idx 0, cnt 0.
  - ready_o 0, cord_err_o 0.
- Payload capture, per router i, on tag_new_i[i]:
  - seen_r[i] <= 1 and req_reset_r[i] <= tag_reset_i[i] at the next edge.
  - Cord: if router_reset_o[i]==1, router_cord_o[i] <= tag_cord_i[i] (visible 1 cycle after the pulse).
  - If router_reset_o[i]==0 and the cord differs, the cord is not updated and cord_err_o sets (sticky until reset_i).
- FSM:
  - HOLD: all router_reset_o=1. When &seen_r and ~|req_reset_r (registered values), next edge:
    - router_reset_o[0] <= 0.
    - If num_router_p==1, go to RUN.
    - Otherwise go to STAGGER with idx <= 1 and cnt <= stagger_cycles_p-1.
  - STAGGER:
    - If cnt==0: router_reset_o[idx] <= 0; if idx==num_router_p-1 go to RUN, else idx++ and cnt <= stagger_cycles_p-1.
    - Else cnt--.
    - Result: release of router k occurs k*stagger_cycles_p cycles after router 0.
  - RUN: holds all released; ready_o=1.
- Re-assertion: in any state, a tag_new_i[i] with tag_reset_i[i]==1 forces, at the next edge:
  - all router_reset_o <= 1 and state <= HOLD;
  - idx and cnt cleared;
  - ready_o low the cycle after.
- Simultaneous events:
  - Re-assertion beats a same-cycle release or HOLD->STAGGER transition.
  - Multiple same-cycle tag_new_i are all captured.
  - A same-cycle reset=1 payload with a new cord latches the cord, because the reset forces router_reset_o to 1 that edge.
- Release order is index ascending: memory routers first, then tiles, matching the chip's cord slicing [0+:num_mem] then [num_mem+:num_core].
- reset_i mid-sequence returns everything to reset values in one edge; seen_r clears, so fresh payloads for every router are required.
- any_reset_o is combinational OR of registered outputs.

Decomposition:
- bsg_chip_pkg gets:
  - router tag payload struct { reset; cord[wh_cord_width_gp] } (moved out of bsg_chip);
  - state enum {e_hold, e_stagger, e_run}.
- One sub-module: bsg_counter_set_down (existing basejump_stl) for the stagger countdown.
- Per-router capture logic is a generate loop, not a module.

Test Plan (num_router_p=4, cord_width_p=7, stagger_cycles_p=3):
- Reset only, no payloads for 50 cycles -> router_reset_o=4'b1111, ready_o=0, cords 0.
- Send reset=0 payloads with cords 0x01..0x04 to routers 0..3 in cycles 10..13 -> cords visible at 11..14; router 0 released at cycle 15, 1 at 18, 2 at 21, 3 at 24; ready_o=1 from cycle 25.
- In RUN, router 2 gets a reset=1 payload at cycle 40 -> all resets 1 and ready_o 0 at 41. Then a reset=0 payload to router 2 at cycle 45 -> router 0 released at 47.
- In RUN, router 1 gets a reset=0 payload with cord 0x55 -> router_cord_o[1] stays 0x02; cord_err_o=1 and stays 1 until reset_i.
- During STAGGER (cycle 19), pulse reset_i -> at cycle 20 all outputs return to reset values and a full re-sequence is required.
- Same cycle: router 3 released while router 0 gets a reset=1 payload -> router_reset_o=4'b1111 next cycle, state HOLD.
